// File: rtl/dht11_reader.sv
// -----------------------------------------------------------------------------
// dht11_reader
// Single-wire DHT11 controller. It sends the host start pulse, checks the
// sensor response, shifts in the 40-bit frame MSB first, and verifies the
// checksum. On a good checksum it publishes the integer humidity and
// temperature bytes.
//
// Ports
//   clk          system clock
//   reset_p      asynchronous, active-high reset
//   clk_usec     one-clk-wide tick, once per microsecond
//   start        one-cycle read request, accepted only in IDLE
//   dht11_data   open-drain data pin; driven 0 or released, never driven 1
//   humidity     integer humidity byte of the last good frame
//   temperature  integer temperature byte of the last good frame
//   valid        one-cycle pulse when humidity/temperature update
//   busy         high whenever the controller is not IDLE
//   error        sticky timeout/checksum flag, cleared by an accepted start
//   state_dbg    current state encoding
// -----------------------------------------------------------------------------
module dht11_reader #(
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 50
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clk_usec,
    input  logic       start,
    inout  wire        dht11_data,
    output logic [7:0] humidity,
    output logic [7:0] temperature,
    output logic       valid,
    output logic       busy,
    output logic       error,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_START_LOW = 4'd1;
    localparam logic [3:0] ST_START_REL = 4'd2;
    localparam logic [3:0] ST_RESP_LOW  = 4'd3;
    localparam logic [3:0] ST_RESP_HIGH = 4'd4;
    localparam logic [3:0] ST_BIT_LOW   = 4'd5;
    localparam logic [3:0] ST_BIT_HIGH  = 4'd6;
    localparam logic [3:0] ST_CHECK     = 4'd7;

    localparam logic [15:0] START_LOW_CNT = 16'(START_LOW_US);
    localparam logic [15:0] TIMEOUT_CNT   = 16'(TIMEOUT_US);
    localparam logic [15:0] THRESH_CNT    = 16'(BIT_THRESH_US);

    // Integer + fractional bytes, 8-bit wrap; compared against the last byte.
    function automatic logic [7:0] frame_checksum(input logic [39:0] frame);
        return frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    endfunction

    logic [3:0]  state_r;
    logic [3:0]  state_nxt_s;
    logic        sync1_r;
    logic        sync2_r;
    logic        dly_r;
    logic        rise_s;
    logic        fall_s;
    logic [15:0] cnt_us_r;
    logic [39:0] shift_r;
    logic [5:0]  bit_idx_r;
    logic        drive_low_r;
    logic        busy_r;
    logic        valid_r;
    logic        error_r;
    logic [7:0]  humidity_r;
    logic [7:0]  temperature_r;
    logic        accept_s;
    logic        timeout_s;
    logic        bit_shift_s;
    logic        sum_ok_s;
    logic        data_state_s;

    assign dht11_data  = drive_low_r ? 1'b0 : 1'bz;
    assign humidity    = humidity_r;
    assign temperature = temperature_r;
    assign valid       = valid_r;
    assign busy        = busy_r;
    assign error       = error_r;
    assign state_dbg   = state_r;

    assign rise_s       = sync2_r & ~dly_r;
    assign fall_s       = ~sync2_r & dly_r;
    assign sum_ok_s     = (frame_checksum(shift_r) == shift_r[7:0]);
    assign data_state_s = (state_r == ST_BIT_LOW) || (state_r == ST_BIT_HIGH);

    // Synchronise the pad and keep a delayed copy for edge strobes; idle line reads high.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            dly_r   <= 1'b1;
        end else begin
            sync1_r <= dht11_data;
            sync2_r <= sync1_r;
            dly_r   <= sync2_r;
        end
    end

    // Next-state decode; a timeout takes priority over a coincident edge.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        timeout_s   = 1'b0;
        bit_shift_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_START_LOW;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START_LOW: begin
                if (cnt_us_r >= START_LOW_CNT) begin
                    state_nxt_s = ST_START_REL;
                end else begin
                    state_nxt_s = ST_START_LOW;
                end
            end
            ST_START_REL, ST_RESP_LOW, ST_RESP_HIGH, ST_BIT_LOW, ST_BIT_HIGH: begin
                if (cnt_us_r >= TIMEOUT_CNT) begin
                    state_nxt_s = ST_IDLE;
                    timeout_s   = 1'b1;
                end else if ((state_r == ST_START_REL) && fall_s) begin
                    state_nxt_s = ST_RESP_LOW;
                end else if ((state_r == ST_RESP_LOW) && rise_s) begin
                    state_nxt_s = ST_RESP_HIGH;
                end else if ((state_r == ST_RESP_HIGH) && fall_s) begin
                    state_nxt_s = ST_BIT_LOW;
                end else if ((state_r == ST_BIT_LOW) && rise_s) begin
                    state_nxt_s = ST_BIT_HIGH;
                end else if ((state_r == ST_BIT_HIGH) && fall_s) begin
                    bit_shift_s = 1'b1;
                    if (bit_idx_r == 6'd39) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_BIT_LOW;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_CHECK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus busy and pin drive, both derived from the next state
    // so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            drive_low_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            drive_low_r <= (state_nxt_s == ST_START_LOW);
        end
    end

    // Microsecond counter: cleared on every transition and on line edges while
    // receiving bits, otherwise advanced by the tick.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_us_r <= 16'd0;
        end else if (state_nxt_s != state_r) begin
            cnt_us_r <= 16'd0;
        end else if (data_state_s && (rise_s || fall_s)) begin
            cnt_us_r <= 16'd0;
        end else if (clk_usec) begin
            cnt_us_r <= cnt_us_r + 16'd1;
        end else begin
            cnt_us_r <= cnt_us_r;
        end
    end

    // Frame shift register and bit index; a high time equal to the threshold is a 0.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            shift_r   <= 40'd0;
            bit_idx_r <= 6'd0;
        end else if (accept_s) begin
            shift_r   <= 40'd0;
            bit_idx_r <= 6'd0;
        end else if ((state_r == ST_RESP_HIGH) && (state_nxt_s == ST_BIT_LOW)) begin
            bit_idx_r <= 6'd0;
        end else if (bit_shift_s) begin
            shift_r   <= {shift_r[38:0], (cnt_us_r > THRESH_CNT)};
            bit_idx_r <= bit_idx_r + 6'd1;
        end else begin
            shift_r   <= shift_r;
            bit_idx_r <= bit_idx_r;
        end
    end

    // Result registers: publish on a good checksum, flag timeouts and bad sums.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            humidity_r    <= 8'd0;
            temperature_r <= 8'd0;
            valid_r       <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (accept_s) begin
                error_r <= 1'b0;
            end else if (timeout_s) begin
                error_r <= 1'b1;
            end else if (state_r == ST_CHECK) begin
                if (sum_ok_s) begin
                    humidity_r    <= shift_r[39:32];
                    temperature_r <= shift_r[23:16];
                    valid_r       <= 1'b1;
                end else begin
                    error_r <= 1'b1;
                end
            end else begin
                error_r <= error_r;
            end
        end
    end

endmodule
